// File: rtl/cache_pkg.sv
// Shared definitions for the cache controller: geometry, FSM states and
// address field extraction helpers.
package cache_pkg;

  localparam int S_OFFSET = 5;
  localparam int S_INDEX  = 3;
  localparam int S_WAY    = 1;
  localparam int NUM_SETS = 1 << S_INDEX;
  localparam int NUM_WAY  = 1 << S_WAY;
  localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    VICTIM,
    WRITEBACK,
    FILL
  } state_t;

  function automatic logic [S_TAG-1:0] addr_tag(input logic [31:0] addr);
    return addr[31:S_OFFSET+S_INDEX];
  endfunction

  function automatic logic [S_INDEX-1:0] addr_set(input logic [31:0] addr);
    return addr[S_OFFSET+S_INDEX-1:S_OFFSET];
  endfunction

  function automatic logic [31:0] line_addr(input logic [S_TAG-1:0] tag,
                                            input logic [S_INDEX-1:0] set);
    return {tag, set, {S_OFFSET{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_tag_array.sv
// Valid/dirty/tag storage for every set and way. Writes land on the clock
// edge; the addressed set is read combinationally for all ways at once.
module cache_tag_array
  import cache_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic [S_INDEX-1:0]              set,
  input  logic [S_WAY-1:0]                way,
  input  logic                            fill,
  input  logic [S_TAG-1:0]                fill_tag,
  input  logic                            set_dirty,
  input  logic                            clr_dirty,
  output logic [NUM_WAY-1:0]              valid,
  output logic [NUM_WAY-1:0]              dirty,
  output logic [NUM_WAY-1:0][S_TAG-1:0]   tags
);

  logic [NUM_SETS-1:0][NUM_WAY-1:0]             valid_q;
  logic [NUM_SETS-1:0][NUM_WAY-1:0]             dirty_q;
  logic [NUM_SETS-1:0][NUM_WAY-1:0][S_TAG-1:0]  tag_q;

  // Line state update: a fill installs a clean valid line, dirty marks follow writes/writebacks.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
      tag_q   <= '0;
    end else begin
      if (fill) begin
        tag_q[set][way]   <= fill_tag;
        valid_q[set][way] <= 1'b1;
        dirty_q[set][way] <= 1'b0;
      end
      if (set_dirty) dirty_q[set][way] <= 1'b1;
      if (clr_dirty) dirty_q[set][way] <= 1'b0;
    end
  end

  assign valid = valid_q[set];
  assign dirty = dirty_q[set];
  assign tags  = tag_q[set];

endmodule

// File: rtl/cache_ctrl.sv
// Set-associative cache control FSM: hit/miss resolution, victim choice with
// the replacement tracker, dirty writeback, line fill and data-array steering.
module cache_ctrl
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         mem_address,
  input  logic                mem_read,
  input  logic                mem_write,
  output logic                mem_resp,
  output logic [31:0]         pmem_address,
  output logic                pmem_read,
  output logic                pmem_write,
  input  logic                pmem_resp,
  output logic [NUM_WAY-1:0]  repl_hit,
  output logic [S_WAY-1:0]    repl_way,
  output logic [S_INDEX-1:0]  repl_set,
  output logic                repl_read,
  output logic                repl_evict,
  input  logic [S_WAY-1:0]    repl_lru,
  output logic [S_WAY-1:0]    data_way,
  output logic                data_load,
  output logic                data_fill
);

  state_t                     state, state_next;
  logic [S_TAG-1:0]           req_tag;
  logic [S_INDEX-1:0]         req_set;
  logic [NUM_WAY-1:0]         valid, dirty;
  logic [NUM_WAY-1:0][S_TAG-1:0] tags;
  logic                       hit;
  logic [S_WAY-1:0]           hit_way;
  logic                       has_inv;
  logic [S_WAY-1:0]           inv_way;
  logic [S_WAY-1:0]           victim_c, victim_q;
  logic [S_WAY-1:0]           arr_way;
  logic                       arr_fill, arr_set_dirty, arr_clr_dirty;

  assign req_tag  = addr_tag(mem_address);
  assign req_set  = addr_set(mem_address);
  assign victim_c = has_inv ? inv_way : repl_lru;

  cache_tag_array u_tags (
    .clk       (clk),
    .rst       (rst),
    .set       (req_set),
    .way       (arr_way),
    .fill      (arr_fill),
    .fill_tag  (req_tag),
    .set_dirty (arr_set_dirty),
    .clr_dirty (arr_clr_dirty),
    .valid     (valid),
    .dirty     (dirty),
    .tags      (tags)
  );

  // Way lookup: scan downwards so the lowest matching / lowest invalid way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = NUM_WAY - 1; w >= 0; w--) begin
      if (valid[w] && (tags[w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = S_WAY'(w);
      end
      if (!valid[w]) begin
        has_inv = 1'b1;
        inv_way = S_WAY'(w);
      end
    end
  end

  // State register; reset abandons any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Victim is captured in VICTIM so later states see a stable choice even if repl_lru moves.
  always_ff @(posedge clk) begin
    if (state == VICTIM) victim_q <= victim_c;
  end

  // Next-state and output decode.
  always_comb begin
    state_next    = state;
    mem_resp      = 1'b0;
    pmem_address  = '0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    repl_hit      = '0;
    repl_way      = '0;
    repl_set      = '0;
    repl_read     = 1'b0;
    repl_evict    = 1'b0;
    data_way      = '0;
    data_load     = 1'b0;
    data_fill     = 1'b0;
    arr_way       = victim_q;
    arr_fill      = 1'b0;
    arr_set_dirty = 1'b0;
    arr_clr_dirty = 1'b0;
    if (state != IDLE) repl_set = req_set;
    unique case (state)
      IDLE: begin
        if (mem_read || mem_write) state_next = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          mem_resp          = 1'b1;
          repl_hit[hit_way] = 1'b1;
          repl_way          = hit_way;
          data_way          = hit_way;
          arr_way           = hit_way;
          // A simultaneous read+write resolves as a write.
          data_load         = mem_write;
          arr_set_dirty     = mem_write;
          state_next        = IDLE;
        end else begin
          repl_read  = 1'b1;
          state_next = VICTIM;
        end
      end
      VICTIM: begin
        if (valid[victim_c] && dirty[victim_c]) state_next = WRITEBACK;
        else                                    state_next = FILL;
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = line_addr(tags[victim_q], req_set);
        data_way     = victim_q;
        if (pmem_resp) begin
          arr_clr_dirty = 1'b1;
          state_next    = FILL;
        end
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = line_addr(req_tag, req_set);
        data_way     = victim_q;
        if (pmem_resp) begin
          data_fill  = 1'b1;
          repl_evict = 1'b1;
          repl_way   = victim_q;
          arr_fill   = 1'b1;
          state_next = COMPARE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: miss/fill, hit, write hit, dirty eviction,
// LRU-driven replacement, read+write collision and mid-fill reset.
module tb_cache_ctrl;
  import cache_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic [31:0]         mem_address;
  logic                mem_read, mem_write, mem_resp;
  logic [31:0]         pmem_address;
  logic                pmem_read, pmem_write, pmem_resp;
  logic [NUM_WAY-1:0]  repl_hit;
  logic [S_WAY-1:0]    repl_way;
  logic [S_INDEX-1:0]  repl_set;
  logic                repl_read, repl_evict;
  logic [S_WAY-1:0]    repl_lru;
  logic [S_WAY-1:0]    data_way;
  logic                data_load, data_fill;

  int total = 0;
  int bad   = 0;

  cache_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_resp     (mem_resp),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_resp    (pmem_resp),
    .repl_hit     (repl_hit),
    .repl_way     (repl_way),
    .repl_set     (repl_set),
    .repl_read    (repl_read),
    .repl_evict   (repl_evict),
    .repl_lru     (repl_lru),
    .data_way     (data_way),
    .data_load    (data_load),
    .data_fill    (data_fill)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Full miss: IDLE, COMPARE, VICTIM, optional WRITEBACK, FILL, re-COMPARE hit.
  task automatic do_miss(input logic [31:0] addr, input logic rd, input logic wr,
                         input logic [S_WAY-1:0] lru, input logic wb,
                         input logic [31:0] wb_addr, input logic [S_WAY-1:0] vway);
    logic [NUM_WAY-1:0] oh;
    oh = '0;
    oh[vway] = 1'b1;
    next_cycle();
    mem_address = addr; mem_read = rd; mem_write = wr; repl_lru = lru;
    @(negedge clk);
    check_eq("miss_idle_resp", mem_resp, 0);
    next_cycle();
    @(negedge clk);
    check_eq("miss_repl_read", repl_read, 1);
    check_eq("miss_cmp_resp", mem_resp, 0);
    check_eq("miss_repl_set", repl_set, addr[7:5]);
    next_cycle();
    @(negedge clk);
    check_eq("victim_repl_read", repl_read, 0);
    check_eq("victim_pmem", {pmem_read, pmem_write}, 0);
    next_cycle();
    if (wb) begin
      @(negedge clk);
      check_eq("wb_pmem_write", pmem_write, 1);
      check_eq("wb_pmem_read", pmem_read, 0);
      check_eq("wb_addr", pmem_address, wb_addr);
      check_eq("wb_data_way", data_way, vway);
      next_cycle();
      pmem_resp = 1'b1;
      @(negedge clk);
      check_eq("wb_no_evict", repl_evict, 0);
      next_cycle();
      pmem_resp = 1'b0;
    end
    @(negedge clk);
    check_eq("fill_pmem_read", pmem_read, 1);
    check_eq("fill_pmem_write", pmem_write, 0);
    check_eq("fill_addr", pmem_address, {addr[31:5], 5'b0});
    check_eq("fill_early", data_fill, 0);
    next_cycle();
    pmem_resp = 1'b1;
    @(negedge clk);
    check_eq("fill_data_fill", data_fill, 1);
    check_eq("fill_evict", repl_evict, 1);
    check_eq("fill_repl_way", repl_way, vway);
    check_eq("fill_data_way", data_way, vway);
    next_cycle();
    pmem_resp = 1'b0;
    @(negedge clk);
    check_eq("recmp_resp", mem_resp, 1);
    check_eq("recmp_hit", repl_hit, oh);
    check_eq("recmp_load", data_load, wr);
    check_eq("recmp_pmem", {pmem_read, pmem_write, repl_read}, 0);
    next_cycle();
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    check_eq("after_resp", mem_resp, 0);
  endtask

  // Hit: response in the cycle after the request is first seen.
  task automatic do_hit(input logic [31:0] addr, input logic rd, input logic wr,
                        input logic [S_WAY-1:0] way);
    logic [NUM_WAY-1:0] oh;
    oh = '0;
    oh[way] = 1'b1;
    next_cycle();
    mem_address = addr; mem_read = rd; mem_write = wr;
    @(negedge clk);
    check_eq("hit_idle_resp", mem_resp, 0);
    next_cycle();
    @(negedge clk);
    check_eq("hit_resp", mem_resp, 1);
    check_eq("hit_onehot", repl_hit, oh);
    check_eq("hit_repl_way", repl_way, way);
    check_eq("hit_data_way", data_way, way);
    check_eq("hit_load", data_load, wr);
    check_eq("hit_quiet", {repl_read, pmem_read, pmem_write, data_fill}, 0);
    next_cycle();
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    check_eq("hit_one_pulse", mem_resp, 0);
  endtask

  initial begin
    rst = 1'b1; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    pmem_resp = 1'b0; repl_lru = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_outputs", {mem_resp, pmem_read, pmem_write, repl_read, repl_evict,
                             data_load, data_fill}, 0);
    check_eq("rst_repl_set", repl_set, 0);
    check_eq("rst_pmem_addr", pmem_address, 0);
    next_cycle();
    rst = 1'b0;

    // Empty cache read to set 2 fills way 0.
    do_miss(32'h0000_0040, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    do_hit (32'h0000_0040, 1'b1, 1'b0, 1'b0);
    // Way 1 is the lowest invalid way even though the tracker says 0.
    do_miss(32'h0000_0140, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    do_hit (32'h0000_0140, 1'b0, 1'b1, 1'b1);
    // Dirty way 1 evicted: writeback of old line 0x140 before fill of 0x240.
    do_miss(32'h0000_0240, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0140, 1'b1);
    // Both clean, tracker picks way 1: no writeback.
    do_miss(32'h0000_0340, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    // Read and write together on a hit behave as a write.
    do_hit (32'h0000_0040, 1'b1, 1'b1, 1'b0);

    // Evict the now-dirty way 0, then reset in the middle of the fill.
    next_cycle();
    mem_address = 32'h0000_0440; mem_read = 1'b1; repl_lru = 1'b0;
    @(negedge clk);
    check_eq("rd_idle", mem_resp, 0);
    next_cycle();
    @(negedge clk);
    check_eq("rd_miss", repl_read, 1);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("rw_dirty_wb", pmem_write, 1);
    check_eq("rw_dirty_addr", pmem_address, 32'h0000_0040);
    next_cycle();
    pmem_resp = 1'b1;
    next_cycle();
    pmem_resp = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_fill", pmem_read, 1);
    check_eq("pre_rst_addr", pmem_address, 32'h0000_0440);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    check_eq("mid_rst_pmem", {pmem_read, pmem_write}, 0);
    check_eq("mid_rst_set", repl_set, 0);
    check_eq("mid_rst_resp", mem_resp, 0);
    next_cycle();
    rst = 1'b0; mem_read = 1'b0;

    // 0x340 was resident before reset; it must now miss into way 0.
    do_miss(32'h0000_0340, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
